// File: rtl/truth_table_sweeper_if.sv
// Purpose: command/status bundle between a truth-table sweeper and its harness.
// Latency: none, wires only.
// Backpressure: none; start/abort are single-cycle requests, status is level/pulse.
//
// Signals:
//   start, abort      harness -> sweeper requests
//   dut_out           gate-under-test output, combinational from drive
//   drive             sweeper -> gate input code
//   busy, done        sweep status (done is a one-cycle pulse)
//   table_out, pass,  observed truth table and comparison results
//   mismatch
interface truth_table_sweeper_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 abort;
   logic                 dut_out;
   logic [N_IN-1:0]      drive;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   table_out;
   logic                 pass;
   logic [2**N_IN-1:0]   mismatch;

   // harness side: issues requests, models the gate, observes results
   modport master (
      output start, abort, dut_out,
      input  drive, busy, done, table_out, pass, mismatch
   );

   // sweeper side
   modport slave (
      input  start, abort, dut_out,
      output drive, busy, done, table_out, pass, mismatch
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Purpose: sweeps every input code of an N_IN-input gate, records its truth table, compares to EXPECTED.
// Latency: done pulses 2**N_IN*(SETTLE_CYCLES+1)+1 clocks after the cycle start is accepted.
// Backpressure: none; start is ignored unless IDLE, abort (DRIVE/SAMPLE only) wins over start.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          truth_table_sweeper_if slave: start/abort/dut_out in,
//                drive/busy/done/table_out/pass/mismatch out (all registered)
module truth_table_sweeper #(
   parameter int                   N_IN          = 3,
   parameter int                   SETTLE_CYCLES = 4,
   parameter logic [2**N_IN-1:0]   EXPECTED      = 8'h5B
) (
   input  logic                    clk,
   input  logic                    rst_n,
   truth_table_sweeper_if.slave    bus
);

   localparam int W = 2**N_IN;

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state_q;
   logic [N_IN:0]     idx_q;       // one spare bit so the last code never wraps
   logic [7:0]        settle_q;
   logic [N_IN-1:0]   drive_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [W-1:0]      table_q;
   logic [W-1:0]      mismatch_q;
   logic [W-1:0]      table_d;
   logic              last_idx;

   assign last_idx = (idx_q == (N_IN+1)'(W-1));

   // Table including the bit being sampled this cycle, so the verdict can be
   // registered on the same edge that enters DONE.
   always_comb begin
      table_d = table_q;
      table_d[idx_q[N_IN-1:0]] = bus.dut_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         settle_q   <= '0;
         drive_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         table_q    <= '0;
         mismatch_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  state_q    <= DRIVE;
                  idx_q      <= '0;
                  drive_q    <= '0;
                  settle_q   <= 8'd1;
                  busy_q     <= 1'b1;
                  table_q    <= '0;
                  pass_q     <= 1'b0;
                  mismatch_q <= '0;
               end
            end
            DRIVE: begin
               if (bus.abort) begin
                  state_q  <= IDLE;
                  idx_q    <= '0;
                  settle_q <= '0;
                  drive_q  <= '0;
                  busy_q   <= 1'b0;
                  pass_q   <= 1'b0;
               end else if (settle_q == 8'(SETTLE_CYCLES)) begin
                  state_q <= SAMPLE;
               end else begin
                  settle_q <= settle_q + 8'd1;
               end
            end
            SAMPLE: begin
               // The sample of the current code is kept even when aborting,
               // so an aborted table holds every code reached so far.
               table_q  <= table_d;
               settle_q <= '0;
               if (bus.abort) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
                  drive_q <= '0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else if (last_idx) begin
                  state_q    <= DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  pass_q     <= (table_d == EXPECTED);
                  mismatch_q <= table_d ^ EXPECTED;
               end else begin
                  state_q  <= DRIVE;
                  idx_q    <= idx_q + (N_IN+1)'(1);
                  drive_q  <= idx_q[N_IN-1:0] + N_IN'(1);
                  settle_q <= 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.drive     = drive_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.table_out = table_q;
   assign bus.pass      = pass_q;
   assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: self-checking bench for truth_table_sweeper (SETTLE=4 and SETTLE=1 instances in parallel).
// Latency: n/a.
// Backpressure: n/a.
module tb_truth_table_sweeper;

   localparam int SA = 4;
   localparam int SB = 1;
   localparam logic [7:0] EXP = 8'h5B;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] code;      // truth table of the behavioural gate

   int total = 0;
   int bad   = 0;

   truth_table_sweeper_if #(.N_IN(3)) ifa ();
   truth_table_sweeper_if #(.N_IN(3)) ifb ();

   assign ifa.start   = start;
   assign ifa.abort   = abort;
   assign ifa.dut_out = code[ifa.drive];
   assign ifb.start   = start;
   assign ifb.abort   = abort;
   assign ifb.dut_out = code[ifb.drive];

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(SA), .EXPECTED(EXP)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(SB), .EXPECTED(EXP)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] code;
      logic [7:0] exp_table;
      logic       exp_pass;
      logic [7:0] exp_mm;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Model: a sweep of 8 codes, each SETTLE+1 clocks, plus one DONE clock.
   function automatic int exp_done(input int s);
      return 8 * (s + 1) + 1;
   endfunction

   // Model: codes whose sample has happened by the end of cycle c.
   function automatic logic [7:0] partial_mask(input int c, input int s);
      int n;
      n = c / (s + 1);
      if (n >= 8) return 8'hFF;
      return 8'((1 << n) - 1);
   endfunction

   // Called on a negedge. Pulses start, then watches 46 cycles (cycle 1 is the
   // first cycle after the accepting edge). Optional second start / abort.
   task automatic run_sweep(input int start_again_at, input int abort_at,
                            output int done_a, output int done_b, output int npulse_a,
                            output int drive_err, output int busy_err,
                            output logic pass_at_done, output logic [7:0] mm_at_done,
                            output logic post_busy, output logic [2:0] post_drive);
      done_a = -1; done_b = -1; npulse_a = 0; drive_err = 0; busy_err = 0;
      pass_at_done = 1'b0; mm_at_done = 8'hxx; post_busy = 1'bx; post_drive = 3'bxxx;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 46; c++) begin
         if (ifa.done) begin
            npulse_a++;
            if (done_a < 0) begin
               done_a       = c;
               pass_at_done = ifa.pass;
               mm_at_done   = ifa.mismatch;
            end
         end
         if (ifb.done && done_b < 0) done_b = c;
         if (abort_at == 0) begin
            if (c <= 40) begin
               if (ifa.drive != 3'((c - 1) / (SA + 1))) drive_err++;
               if (!ifa.busy) busy_err++;
            end else if (ifa.busy) begin
               busy_err++;
            end
         end
         if (c == abort_at + 1) begin
            post_busy  = ifa.busy;
            post_drive = ifa.drive;
         end
         start = (c == start_again_at);
         abort = (c == abort_at);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic full_check(input string tag, input logic [7:0] c, input int sa_again);
      int da, db, np, de, be;
      logic pd, pb;
      logic [7:0] md;
      logic [2:0] pdr;
      code = c;
      run_sweep(sa_again, 0, da, db, np, de, be, pd, md, pb, pdr);
      chk({tag, "_done_cyc_a"}, 32'(da), 32'(exp_done(SA)));
      chk({tag, "_done_cyc_b"}, 32'(db), 32'(exp_done(SB)));
      chk({tag, "_npulse"},     32'(np), 32'd1);
      chk({tag, "_table_a"},    32'(ifa.table_out), 32'(c));
      chk({tag, "_table_b"},    32'(ifb.table_out), 32'(c));
      chk({tag, "_pass"},       32'(ifa.pass), 32'(c == EXP));
      chk({tag, "_mismatch"},   32'(ifa.mismatch), 32'(c ^ EXP));
      chk({tag, "_pass_at_done"}, 32'(pd), 32'(c == EXP));
      chk({tag, "_mm_at_done"},   32'(md), 32'(c ^ EXP));
      chk({tag, "_drive_seq"},  32'(de), 32'd0);
      chk({tag, "_busy_seq"},   32'(be), 32'd0);
      chk({tag, "_drive_hold"}, 32'(ifa.drive), 32'd7);
   endtask

   task automatic abort_check(input string tag, input logic [7:0] c, input int at);
      int da, db, np, de, be;
      logic pd, pb;
      logic [7:0] md;
      logic [2:0] pdr;
      code = c;
      run_sweep(0, at, da, db, np, de, be, pd, md, pb, pdr);
      chk({tag, "_post_busy"},  32'(pb), 32'd0);
      chk({tag, "_post_drive"}, 32'(pdr), 32'd0);
      chk({tag, "_npulse"},     32'(np), 32'd0);
      chk({tag, "_table"},      32'(ifa.table_out), 32'(c & partial_mask(at, SA)));
      chk({tag, "_pass"},       32'(ifa.pass), 32'd0);
   endtask

   initial begin
      vecs[0] = '{code: 8'h5B, exp_table: 8'h5B, exp_pass: 1'b1, exp_mm: 8'h00};
      vecs[1] = '{code: 8'h00, exp_table: 8'h00, exp_pass: 1'b0, exp_mm: 8'h5B};
      vecs[2] = '{code: 8'h53, exp_table: 8'h53, exp_pass: 1'b0, exp_mm: 8'h08};
      vecs[3] = '{code: 8'hFF, exp_table: 8'hFF, exp_pass: 1'b0, exp_mm: 8'hA4};
      vecs[4] = '{code: 8'hA4, exp_table: 8'hA4, exp_pass: 1'b0, exp_mm: 8'hFF};
      vecs[5] = '{code: 8'h5A, exp_table: 8'h5A, exp_pass: 1'b0, exp_mm: 8'h01};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; code = EXP;
      repeat (3) @(negedge clk);
      chk("rst_drive",    32'(ifa.drive), 32'd0);
      chk("rst_busy",     32'(ifa.busy), 32'd0);
      chk("rst_done",     32'(ifa.done), 32'd0);
      chk("rst_table",    32'(ifa.table_out), 32'd0);
      chk("rst_pass",     32'(ifa.pass), 32'd0);
      chk("rst_mismatch", 32'(ifa.mismatch), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven sweeps with fixed gate functions.
      for (int i = 0; i < 6; i++) begin
         int da, db, np, de, be;
         logic pd, pb;
         logic [7:0] md;
         logic [2:0] pdr;
         code = vecs[i].code;
         run_sweep(0, 0, da, db, np, de, be, pd, md, pb, pdr);
         chk($sformatf("vec%0d_done_cyc", i), 32'(da), 32'(exp_done(SA)));
         chk($sformatf("vec%0d_done_cyc_s1", i), 32'(db), 32'(exp_done(SB)));
         chk($sformatf("vec%0d_table", i), 32'(ifa.table_out), 32'(vecs[i].exp_table));
         chk($sformatf("vec%0d_pass", i), 32'(ifa.pass), 32'(vecs[i].exp_pass));
         chk($sformatf("vec%0d_mismatch", i), 32'(ifa.mismatch), 32'(vecs[i].exp_mm));
         chk($sformatf("vec%0d_drive_seq", i), 32'(de), 32'd0);
         chk($sformatf("vec%0d_busy_seq", i), 32'(be), 32'd0);
      end

      // start re-pulsed mid-sweep must be ignored.
      full_check("restart10", EXP, 10);

      // abort in the SAMPLE cycle of code 3, then a clean sweep.
      abort_check("abort20", EXP, 20);
      chk("abort20_table_exact", 32'(ifa.table_out), 32'h0B);
      full_check("after_abort", EXP, 0);

      // abort and start coinciding in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_same_busy", 32'(ifa.busy), 32'd0);
      @(negedge clk);

      // Randomized gates, with or without an abort.
      for (int r = 0; r < 16; r++) begin
         logic [7:0] rc;
         rc = 8'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            full_check($sformatf("rnd%0d", r), rc, 0);
         end else begin
            abort_check($sformatf("rnd%0d_ab", r), rc, int'($urandom_range(1, 40)));
         end
      end

      // Reset asserted between edges mid-sweep.
      code = EXP;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("pre_rst_drive", 32'(ifa.drive), 32'd2);
      chk("pre_rst_table", 32'(ifa.table_out), 32'h03);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_drive",    32'(ifa.drive), 32'd0);
      chk("async_rst_busy",     32'(ifa.busy), 32'd0);
      chk("async_rst_done",     32'(ifa.done), 32'd0);
      chk("async_rst_table",    32'(ifa.table_out), 32'd0);
      chk("async_rst_pass",     32'(ifa.pass), 32'd0);
      chk("async_rst_mismatch", 32'(ifa.mismatch), 32'd0);
      chk("async_rst_b_busy",   32'(ifb.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      full_check("after_rst", EXP, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
